// File: rtl/ifetch_buffer.sv
// Instruction prefetch buffer sitting in front of the F/D pipe register.
// Owns the fetch PC and issues in-order word requests on a grant/rvalid port.
// Returned words are queued with their PCs, and the queue head is presented
// to decode through a registered output stage.
// A taken branch/jump flushes the queue and drops any words that are still
// in flight when they come back.
module ifetch_buffer #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned MAX_OUT  = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4
);

  localparam int unsigned PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW  = PW + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  // Force an address onto a word boundary.
  function automatic logic [31:0] wordAlign(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

  // Fetch-side control state
  logic [31:0]   fpc;
  logic [31:0]   retPc;
  logic [CW-1:0] count;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] discard;
  logic [PW-1:0] rdPtr;
  logic [PW-1:0] wrPtr;

  // Queue storage (data only, never reset)
  logic [31:0]   qInstr [DEPTH];
  logic [31:0]   qPc    [DEPTH];

  // Registered head presented to decode
  logic          vld_p1;
  logic [31:0]   instr_p1;
  logic [31:0]   pc_p1;

  // Per-cycle decisions
  logic [CW-1:0] liveOut;
  logic [CW:0]   credit;
  logic          canIssue;
  logic          grant;
  logic          ret;
  logic          push;
  logic          pop;
  logic [CW-1:0] outNext;
  logic [CW-1:0] remain;
  logic [PW-1:0] rdPtrNext;

  // Only the word-aligned part of the redirect target is meaningful.
  logic          unusedPcBits;
  assign unusedPcBits = ^redirect_pc[1:0];

  // Issue, return and head-advance decisions for the current cycle.
  always_comb begin
    liveOut   = outstanding - discard;
    credit    = {1'b0, count} + {1'b0, liveOut};
    // Held low while reset is asserted; credit keeps every live word a queue slot.
    canIssue  = rst_n && (outstanding < CW'(MAX_OUT)) && (credit < (CW + 1)'(DEPTH));
    mem_req   = canIssue && !redirect;
    mem_addr  = wordAlign(fpc);
    // A grant in a redirect cycle still counts: that word is later discarded.
    grant     = canIssue && mem_gnt;
    // Stray responses with nothing outstanding (e.g. right after reset) are ignored.
    ret       = mem_rvalid && (outstanding != '0);
    push      = ret && !redirect && (discard == '0);
    pop       = vld_p1 && !stall && !redirect;
    outNext   = outstanding + CW'(grant) - CW'(ret);
    remain    = count - CW'(pop);
    rdPtrNext = pop ? (rdPtr + PW'(1)) : rdPtr;
  end

  // Fetch PC, in-flight accounting and queue pointers; redirect wins over everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fpc         <= wordAlign(RESET_PC);
      retPc       <= wordAlign(RESET_PC);
      count       <= '0;
      outstanding <= '0;
      discard     <= '0;
      rdPtr       <= '0;
      wrPtr       <= '0;
    end else begin
      outstanding <= outNext;
      if (redirect) begin
        fpc     <= wordAlign(redirect_pc);
        retPc   <= wordAlign(redirect_pc);
        count   <= '0;
        rdPtr   <= '0;
        wrPtr   <= '0;
        discard <= outNext;
      end else begin
        if (grant) begin
          fpc <= fpc + 32'd4;
        end
        if (ret && (discard != '0)) begin
          discard <= discard - CW'(1);
        end
        if (push) begin
          wrPtr <= wrPtr + PW'(1);
          retPc <= retPc + 32'd4;
        end
        if (pop) begin
          rdPtr <= rdPtr + PW'(1);
        end
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  // Queue write port: accepted words stored with the PC they were fetched from.
  always_ff @(posedge clk) begin
    if (push) begin
      qInstr[wrPtr] <= mem_rdata;
      qPc[wrPtr]    <= retPc;
    end
  end

  // ---- stage p1: head register; words pushed this edge appear one edge later ----
  // Load the entry that will be at the head after this edge's pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1   <= 1'b0;
      instr_p1 <= NOP;
      pc_p1    <= 32'd0;
    end else if (redirect || (remain == '0)) begin
      vld_p1   <= 1'b0;
      instr_p1 <= NOP;
      pc_p1    <= 32'd0;
    end else begin
      vld_p1   <= 1'b1;
      instr_p1 <= qInstr[rdPtrNext];
      pc_p1    <= qPc[rdPtrNext];
    end
  end

  assign instr_valid = vld_p1;
  assign instr       = instr_p1;
  assign pc          = pc_p1;
  assign pc_plus4    = pc_p1 + 32'd4;

`ifndef SYNTHESIS
  // A returned word must never find the queue full.
  always @(posedge clk) begin
    if (rst_n && push && !pop) begin
      assert (count < CW'(DEPTH));
    end
  end
`endif

endmodule

// File: tb/tb_ifetch_buffer.sv
// Directed bench for ifetch_buffer: reset, streaming/backpressure table,
// redirect corner cases and PC wrap on a second instance.
module tb_ifetch_buffer;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        stall = 1'b0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] pc_plus4;

  logic        modelEn = 1'b0;
  logic        modelRvalid = 1'b0;
  logic [31:0] modelRdata = 32'd0;
  logic        forceRvalid = 1'b0;
  int unsigned lat = 1;
  logic [31:0] cyc = 32'd0;

  // wrap instance signals
  logic        wReq;
  logic [31:0] wAddr;
  logic        wRvalid = 1'b0;
  logic [31:0] wRdata = 32'd0;
  logic        wVld;
  logic [31:0] wInstr;
  logic [31:0] wPc;
  logic [31:0] wPc4;
  logic        wPend = 1'b0;
  logic [31:0] wPendAddr = 32'd0;

  int nCmp = 0;
  int nFail = 0;

  always #5 clk = ~clk;

  // Instruction image: word content derived from its address.
  function automatic logic [31:0] img(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  assign mem_rvalid = modelEn ? modelRvalid : forceRvalid;
  assign mem_rdata  = modelEn ? modelRdata  : 32'hDEAD_BEEF;

  ifetch_buffer dut (
    .clk(clk), .rst_n(rst_n), .redirect(redirect), .redirect_pc(redirect_pc),
    .stall(stall), .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .instr_valid(instr_valid),
    .instr(instr), .pc(pc), .pc_plus4(pc_plus4)
  );

  ifetch_buffer #(.RESET_PC(32'hFFFF_FFF8)) dutWrap (
    .clk(clk), .rst_n(rst_n), .redirect(1'b0), .redirect_pc(32'd0),
    .stall(1'b0), .mem_req(wReq), .mem_addr(wAddr), .mem_gnt(1'b1),
    .mem_rvalid(wRvalid), .mem_rdata(wRdata), .instr_valid(wVld),
    .instr(wInstr), .pc(wPc), .pc_plus4(wPc4)
  );

  // Fixed-latency in-order memory for the main instance.
  typedef struct {
    logic [31:0] addr;
    logic [31:0] due;
  } pend_t;
  pend_t pendQ[$];

  always @(posedge clk) begin
    if (!rst_n) pendQ.delete();
    else if (mem_gnt && (mem_req || redirect)) pendQ.push_back('{addr: mem_addr, due: cyc + lat});
    cyc <= cyc + 32'd1;
  end

  always @(negedge clk) begin
    if (rst_n && (pendQ.size() > 0) && (pendQ[0].due <= cyc)) begin
      modelRvalid <= 1'b1;
      modelRdata  <= img(pendQ[0].addr);
      void'(pendQ.pop_front());
    end else begin
      modelRvalid <= 1'b0;
    end
  end

  // Zero-wait memory for the wrap instance.
  always @(posedge clk) begin
    wPend     <= rst_n && wReq;
    wPendAddr <= wAddr;
  end
  always @(negedge clk) begin
    wRvalid <= wPend && rst_n;
    wRdata  <= img(wPendAddr);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic doReset(input int unsigned l);
    @(negedge clk);
    rst_n = 1'b0; redirect = 1'b0; stall = 1'b0; mem_gnt = 1'b1; modelEn = 1'b1; lat = l;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic waitValid(input int maxCyc, output logic [31:0] p, output logic [31:0] ins,
                           output logic ok);
    ok = 1'b0; p = 32'd0; ins = 32'd0;
    for (int i = 0; i < maxCyc && !ok; i++) begin
      step();
      if (instr_valid) begin
        ok = 1'b1; p = pc; ins = instr;
      end
    end
  endtask

  typedef struct {
    logic        stall;
    logic        expVld;
    logic [31:0] expPc;
    logic        expReq;
  } vec_t;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[19];
    logic [31:0] eP, eI, gotP, gotI;
    logic        ok;

    // rows: after edge 1..19 from first grant-enabled cycle
    vecs[0] = '{1'b0, 1'b0, 32'd0, 1'b1};
    vecs[1] = '{1'b0, 1'b0, 32'd0, 1'b1};
    vecs[2] = '{1'b0, 1'b1, 32'd0, 1'b1};
    for (int i = 3; i < 13; i++) vecs[i] = '{1'b1, 1'b1, 32'd0, 1'b0};
    for (int i = 13; i < 19; i++) vecs[i] = '{1'b0, 1'b1, 32'(4 * (i - 12)), 1'b1};

    // T1: reset held with rvalid toggling
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      forceRvalid = ~forceRvalid;
    end
    @(negedge clk);
    chk("rst mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst instr_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst instr", instr, NOP);
    chk("rst pc", pc, 32'd0);
    chk("rst pc_plus4", pc_plus4, 32'd4);
    chk("rst wrap mem_req", {31'd0, wReq}, 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      forceRvalid = ~forceRvalid;
      @(negedge clk);
    end
    chk("stray rvalid valid", {31'd0, instr_valid}, 32'd0);
    chk("first req", {31'd0, mem_req}, 32'd1);
    chk("first addr", mem_addr, 32'd0);
    forceRvalid = 1'b0; modelEn = 1'b1; mem_gnt = 1'b1;

    // T2/T3: streaming then 10-cycle stall, table driven
    for (int i = 0; i < 19; i++) begin
      stall = vecs[i].stall;
      step();
      eP = vecs[i].expVld ? vecs[i].expPc : 32'd0;
      eI = vecs[i].expVld ? img(eP) : NOP;
      chk($sformatf("row%0d valid", i), {31'd0, instr_valid}, {31'd0, vecs[i].expVld});
      chk($sformatf("row%0d pc", i), pc, eP);
      chk($sformatf("row%0d instr", i), instr, eI);
      chk($sformatf("row%0d pc_plus4", i), pc_plus4, eP + 32'd4);
      chk($sformatf("row%0d mem_req", i), {31'd0, mem_req}, {31'd0, vecs[i].expReq});
    end
    stall = 1'b0;

    // T6: wrap of the fetch PC
    doReset(1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("wrap pc0", wPc, 32'hFFFF_FFF8);
    chk("wrap instr0", wInstr, img(32'hFFFF_FFF8));
    step();
    chk("wrap pc1", wPc, 32'hFFFF_FFFC);
    chk("wrap pc4 1", wPc4, 32'h0000_0000);
    step();
    chk("wrap pc2", wPc, 32'h0000_0000);
    chk("wrap valid2", {31'd0, wVld}, 32'd1);
    chk("wrap pc4 2", wPc4, 32'h0000_0004);

    // T4: redirect with two words in flight, 3-cycle memory
    doReset(3);
    step();
    step();
    redirect = 1'b1; redirect_pc = 32'h0000_0100; mem_gnt = 1'b0;
    step();
    redirect = 1'b0; mem_gnt = 1'b1;
    chk("t4 flush valid", {31'd0, instr_valid}, 32'd0);
    waitValid(40, gotP, gotI, ok);
    chk("t4 first found", {31'd0, ok}, 32'd1);
    chk("t4 first pc", gotP, 32'h0000_0100);
    chk("t4 first instr", gotI, img(32'h0000_0100));
    waitValid(40, gotP, gotI, ok);
    chk("t4 second found", {31'd0, ok}, 32'd1);
    chk("t4 second pc", gotP, 32'h0000_0104);

    // T5: redirect coinciding with grant and return, unaligned target
    doReset(1);
    step(); step(); step();
    chk("t5 pre pc", pc, 32'd0);
    redirect = 1'b1; redirect_pc = 32'h0000_0103;
    #1;
    chk("t5 req forced low", {31'd0, mem_req}, 32'd0);
    @(negedge clk);
    redirect = 1'b0;
    #1;
    chk("t5 post valid", {31'd0, instr_valid}, 32'd0);
    chk("t5 post req", {31'd0, mem_req}, 32'd1);
    chk("t5 post addr", mem_addr, 32'h0000_0100);
    @(negedge clk);
    chk("t5 n+1 valid", {31'd0, instr_valid}, 32'd0);
    step();
    chk("t5 n+2 valid", {31'd0, instr_valid}, 32'd0);
    step();
    chk("t5 n+3 valid", {31'd0, instr_valid}, 32'd1);
    chk("t5 n+3 pc", pc, 32'h0000_0100);
    chk("t5 n+3 instr", instr, img(32'h0000_0100));
    chk("t5 n+3 pc_plus4", pc_plus4, 32'h0000_0104);
    step();
    chk("t5 n+4 pc", pc, 32'h0000_0104);

    // T7: back-to-back redirects with one word in flight
    doReset(3);
    step();
    redirect = 1'b1; redirect_pc = 32'h0000_0200; mem_gnt = 1'b0;
    step();
    redirect_pc = 32'h0000_0300;
    step();
    redirect = 1'b0; mem_gnt = 1'b1;
    waitValid(40, gotP, gotI, ok);
    chk("t7 found", {31'd0, ok}, 32'd1);
    chk("t7 pc", gotP, 32'h0000_0300);
    chk("t7 instr", gotI, img(32'h0000_0300));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

endmodule
